// File: rtl/axi_mem_slave_if.sv
// axi_mem_slave_if: AXI4 full bus bundle between a master and axi_mem_slave.
//   Parameters: C_S_AXI_ADDR_WIDTH (byte address), C_S_AXI_DATA_WIDTH (data bits).
//   Channels:   AW (address/len/size/burst + ignored lock/cache/prot/qos),
//               W (data/strb/last), B (resp), AR (as AW), R (data/resp/last).
//   Modports:   slave  - responder view (drives readies, B and R payload)
//               master - requester view (drives AW/W/AR payload, bready, rready)
interface axi_mem_slave_if #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic [7:0]                      s_axi_awlen;
    logic [2:0]                      s_axi_awsize;
    logic [1:0]                      s_axi_awburst;
    logic                            s_axi_awlock;
    logic [3:0]                      s_axi_awcache;
    logic [2:0]                      s_axi_awprot;
    logic [3:0]                      s_axi_awqos;
    logic                            s_axi_awvalid;
    logic                            s_axi_awready;

    logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                            s_axi_wlast;
    logic                            s_axi_wvalid;
    logic                            s_axi_wready;

    logic [1:0]                      s_axi_bresp;
    logic                            s_axi_bvalid;
    logic                            s_axi_bready;

    logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr;
    logic [7:0]                      s_axi_arlen;
    logic [2:0]                      s_axi_arsize;
    logic [1:0]                      s_axi_arburst;
    logic                            s_axi_arlock;
    logic [3:0]                      s_axi_arcache;
    logic [2:0]                      s_axi_arprot;
    logic [3:0]                      s_axi_arqos;
    logic                            s_axi_arvalid;
    logic                            s_axi_arready;

    logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]                      s_axi_rresp;
    logic                            s_axi_rlast;
    logic                            s_axi_rvalid;
    logic                            s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock,
               s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arlock,
               s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready
    );

    modport master (
        output s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock,
               s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arlock,
               s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready
    );
endinterface

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 memory responder backed by a C_MEM_DEPTH x DATA_W array.
//   s_axi_aclk    - clock
//   s_axi_aresetn - asynchronous active-low reset (memory contents are kept)
//   s_axi         - axi_mem_slave_if.slave bundle (AW, W, B, AR, R channels)
// Independent write (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_FETCH/R_DATA)
// FSMs. Word index = addr >> log2(DATA_W/8); bursts starting beyond the
// array answer SLVERR, write nothing and read zero.
module axi_mem_slave #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_DEPTH        = 1024
) (
    input logic              s_axi_aclk,
    input logic              s_axi_aresetn,
    axi_mem_slave_if.slave   s_axi
);
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(C_MEM_DEPTH);
    localparam int HI     = LSB + IDX_W;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [C_MEM_DEPTH];

    // Write channel state
    wstate_t                       r_wstate;
    logic                          r_awready, r_wready, r_bvalid;
    logic [1:0]                    r_bresp;
    logic [IDX_W-1:0]              r_widx;
    logic [7:0]                    r_wlen, r_wbeat;
    logic                          r_wfixed, r_woor, r_werr;

    // Read channel state
    rstate_t                       r_rstate;
    logic                          r_arready, r_rvalid, r_rlast;
    logic [1:0]                    r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [IDX_W-1:0]              r_ridx;
    logic [7:0]                    r_rlen, r_rbeat;
    logic                          r_rfixed, r_roor;

    logic w_aw_oor, w_ar_oor, w_wlast_exp, w_wbeat_err, w_wbeat, w_mem_we;

    // Any address bit above the word index means the start word is out of range.
    assign w_aw_oor    = |(s_axi.s_axi_awaddr >> HI);
    assign w_ar_oor    = |(s_axi.s_axi_araddr >> HI);
    assign w_wbeat     = s_axi.s_axi_wvalid && r_wready;
    assign w_wlast_exp = (r_wbeat == r_wlen);
    assign w_wbeat_err = (s_axi.s_axi_wlast != w_wlast_exp);
    assign w_mem_we    = (r_wstate == W_DATA) && w_wbeat && !r_woor;

    // Sideband fields and sub-word address bits carry no meaning here.
    logic w_unused;
    assign w_unused = ^{s_axi.s_axi_awaddr[LSB-1:0], s_axi.s_axi_araddr[LSB-1:0],
                        s_axi.s_axi_awsize, s_axi.s_axi_awlock, s_axi.s_axi_awcache,
                        s_axi.s_axi_awprot, s_axi.s_axi_awqos,
                        s_axi.s_axi_arsize, s_axi.s_axi_arlock, s_axi.s_axi_arcache,
                        s_axi.s_axi_arprot, s_axi.s_axi_arqos};

    always_ff @(posedge s_axi_aclk) begin
        if (w_mem_we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (s_axi.s_axi_wstrb[b])
                    r_mem[r_widx][8*b +: 8] <= s_axi.s_axi_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= '0;
            r_widx    <= '0;
            r_wlen    <= '0;
            r_wbeat   <= '0;
            r_wfixed  <= 1'b0;
            r_woor    <= 1'b0;
            r_werr    <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (s_axi.s_axi_awvalid && r_awready) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_widx    <= s_axi.s_axi_awaddr[LSB +: IDX_W];
                        r_wlen    <= s_axi.s_axi_awlen;
                        r_wfixed  <= (s_axi.s_axi_awburst == 2'b00);
                        r_woor    <= w_aw_oor;
                        r_werr    <= 1'b0;
                        r_wbeat   <= '0;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_wbeat) begin
                        if (w_wbeat_err)
                            r_werr <= 1'b1;
                        // Beat count alone ends the burst; wlast only feeds bresp.
                        if (w_wlast_exp) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_woor || r_werr || w_wbeat_err) ? 2'b10 : 2'b00;
                            r_wstate <= W_RESP;
                        end else begin
                            r_wbeat <= r_wbeat + 8'd1;
                            if (!r_wfixed)
                                r_widx <= r_widx + IDX_W'(1);
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.s_axi_bready && r_bvalid) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= '0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= '0;
            r_rdata   <= '0;
            r_ridx    <= '0;
            r_rlen    <= '0;
            r_rbeat   <= '0;
            r_rfixed  <= 1'b0;
            r_roor    <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (s_axi.s_axi_arvalid && r_arready) begin
                        r_arready <= 1'b0;
                        r_ridx    <= s_axi.s_axi_araddr[LSB +: IDX_W];
                        r_rlen    <= s_axi.s_axi_arlen;
                        r_rfixed  <= (s_axi.s_axi_arburst == 2'b00);
                        r_roor    <= w_ar_oor;
                        r_rbeat   <= '0;
                        r_rstate  <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    r_rdata  <= r_roor ? '0 : r_mem[r_ridx];
                    r_rresp  <= r_roor ? 2'b10 : 2'b00;
                    r_rlast  <= (r_rbeat == r_rlen);
                    r_rvalid <= 1'b1;
                    r_rstate <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi.s_axi_rready && r_rvalid) begin
                        r_rvalid <= 1'b0;
                        if (r_rlast) begin
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rbeat  <= r_rbeat + 8'd1;
                            if (!r_rfixed)
                                r_ridx <= r_ridx + IDX_W'(1);
                            r_rstate <= R_FETCH;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi.s_axi_awready = r_awready;
    assign s_axi.s_axi_wready  = r_wready;
    assign s_axi.s_axi_bvalid  = r_bvalid;
    assign s_axi.s_axi_bresp   = r_bresp;
    assign s_axi.s_axi_arready = r_arready;
    assign s_axi.s_axi_rvalid  = r_rvalid;
    assign s_axi.s_axi_rdata   = r_rdata;
    assign s_axi.s_axi_rresp   = r_rresp;
    assign s_axi.s_axi_rlast   = r_rlast;
endmodule

// File: tb/tb_axi_mem_slave.sv
module tb_axi_mem_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_mem_slave_if #(.C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32)) bus ();

    axi_mem_slave #(
        .C_S_AXI_ADDR_WIDTH(32),
        .C_S_AXI_DATA_WIDTH(32),
        .C_MEM_DEPTH(1024)
    ) dut (
        .s_axi_aclk(clk),
        .s_axi_aresetn(rst_n),
        .s_axi(bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } rbeat_t;

    logic [31:0] mdl [0:1023];
    logic [31:0] wbuf [0:15];
    logic [1:0]  bq [$];
    rbeat_t      rq [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_oor(input logic [31:0] a);
        return (a >= 32'h1000);
    endfunction

    task automatic do_aw(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int t = 0;
        bus.s_axi_awaddr  = addr;
        bus.s_axi_awlen   = len;
        bus.s_axi_awburst = burst;
        bus.s_axi_awsize  = 3'd2;
        bus.s_axi_awvalid = 1'b1;
        while (!bus.s_axi_awready && t < 50) begin step(); t++; end
        if (t >= 50) chk("aw_timeout", 0, 1);
        step();
        bus.s_axi_awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int t = 0;
        bus.s_axi_wdata  = data;
        bus.s_axi_wstrb  = strb;
        bus.s_axi_wlast  = last;
        bus.s_axi_wvalid = 1'b1;
        while (!bus.s_axi_wready && t < 50) begin step(); t++; end
        if (t >= 50) chk("w_timeout", 0, 1);
        step();
        bus.s_axi_wvalid = 1'b0;
        bus.s_axi_wlast  = 1'b0;
    endtask

    task automatic do_b(input int delay);
        int t = 0;
        logic [1:0] e;
        bus.s_axi_bready = 1'b0;
        while (!bus.s_axi_bvalid && t < 50) begin step(); t++; end
        if (t >= 50) chk("b_timeout", 0, 1);
        for (int i = 0; i < delay; i++) begin
            step();
            chk("b_hold_valid", bus.s_axi_bvalid, 1);
            chk("b_hold_awready", bus.s_axi_awready, 0);
        end
        e = bq.pop_front();
        chk("bresp", bus.s_axi_bresp, e);
        bus.s_axi_bready = 1'b1;
        step();
        bus.s_axi_bready = 1'b0;
        chk("bvalid_clear", bus.s_axi_bvalid, 0);
    endtask

    // bad: beat index whose wlast is inverted (-1 = all correct)
    task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input logic [3:0] strb, input int bad, input int bdelay);
        logic oor = is_oor(addr);
        logic [9:0] idx = addr[11:2];
        bq.push_back((oor || bad >= 0) ? 2'b10 : 2'b00);
        do_aw(addr, 8'(len), burst);
        for (int b = 0; b <= len; b++) begin
            do_w(wbuf[b], strb, (b == len) != (b == bad));
            if (!oor)
                for (int k = 0; k < 4; k++)
                    if (strb[k]) mdl[idx][8*k +: 8] = wbuf[b][8*k +: 8];
            if (burst != 2'b00) idx++;
        end
        do_b(bdelay);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input int rdelay);
        logic oor = is_oor(addr);
        logic [9:0] idx = addr[11:2];
        int t;
        rbeat_t e;
        for (int b = 0; b <= len; b++) begin
            rq.push_back('{d: oor ? 32'h0 : mdl[idx], r: oor ? 2'b10 : 2'b00, l: (b == len)});
            if (burst != 2'b00) idx++;
        end
        bus.s_axi_araddr  = addr;
        bus.s_axi_arlen   = 8'(len);
        bus.s_axi_arburst = burst;
        bus.s_axi_arsize  = 3'd2;
        bus.s_axi_arvalid = 1'b1;
        t = 0;
        while (!bus.s_axi_arready && t < 50) begin step(); t++; end
        if (t >= 50) chk("ar_timeout", 0, 1);
        step();
        bus.s_axi_arvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            t = 0;
            while (!bus.s_axi_rvalid && t < 50) begin step(); t++; end
            chk("r_latency", t, 1);
            e = rq.pop_front();
            chk("rdata", bus.s_axi_rdata, e.d);
            chk("rresp", bus.s_axi_rresp, e.r);
            chk("rlast", bus.s_axi_rlast, e.l);
            if (b == 0)
                for (int i = 0; i < rdelay; i++) begin
                    step();
                    chk("r_hold_valid", bus.s_axi_rvalid, 1);
                    chk("r_hold_data", bus.s_axi_rdata, e.d);
                end
            bus.s_axi_rready = 1'b1;
            step();
            bus.s_axi_rready = 1'b0;
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_awready"}, bus.s_axi_awready, 0);
        chk({tag, "_wready"},  bus.s_axi_wready, 0);
        chk({tag, "_bvalid"},  bus.s_axi_bvalid, 0);
        chk({tag, "_arready"}, bus.s_axi_arready, 0);
        chk({tag, "_rvalid"},  bus.s_axi_rvalid, 0);
        chk({tag, "_rlast"},   bus.s_axi_rlast, 0);
        chk({tag, "_bresp"},   bus.s_axi_bresp, 0);
        chk({tag, "_rresp"},   bus.s_axi_rresp, 0);
        chk({tag, "_rdata"},   bus.s_axi_rdata, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awsize = '0;
        bus.s_axi_awburst = 2'b01; bus.s_axi_awlock = 1'b0; bus.s_axi_awcache = '0;
        bus.s_axi_awprot = '0; bus.s_axi_awqos = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0;
        bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0;
        bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arsize = '0;
        bus.s_axi_arburst = 2'b01; bus.s_axi_arlock = 1'b0; bus.s_axi_arcache = '0;
        bus.s_axi_arprot = '0; bus.s_axi_arqos = '0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready = 1'b0;

        // Reset state, then readies on the first edge after release
        step(); step();
        chk_idle_zero("rst");
        rst_n = 1'b1;
        step();
        chk("post_rst_awready", bus.s_axi_awready, 1);
        chk("post_rst_arready", bus.s_axi_arready, 1);

        // Single-beat write/read
        wbuf[0] = 32'hDEADBEEF;
        axi_write(32'h10, 0, 2'b01, 4'hF, -1, 0);
        axi_read(32'h10, 0, 2'b01, 0);

        // INCR burst, then FIXED read of the first word twice
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        axi_write(32'h100, 3, 2'b01, 4'hF, -1, 0);
        axi_read(32'h100, 3, 2'b01, 0);
        axi_read(32'h100, 1, 2'b00, 0);

        // WRAP behaves as INCR
        axi_read(32'h100, 3, 2'b10, 0);

        // Partial strobe merge
        wbuf[0] = 32'hDEADBEEF;
        axi_write(32'h20, 0, 2'b01, 4'hF, -1, 0);
        wbuf[0] = 32'h0000FFFF;
        axi_write(32'h20, 0, 2'b01, 4'h3, -1, 0);
        axi_read(32'h20, 0, 2'b01, 0);

        // FIXED write: last beat wins
        wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC;
        axi_write(32'h60, 2, 2'b00, 4'hF, -1, 0);
        axi_read(32'h60, 0, 2'b01, 0);

        // Index wraps modulo depth
        wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222;
        axi_write(32'hFFC, 1, 2'b01, 4'hF, -1, 0);
        axi_read(32'hFFC, 1, 2'b01, 0);

        // Out of range and early wlast
        wbuf[0] = 32'h5555_5555; wbuf[1] = 32'h6666_6666;
        axi_write(32'h1000, 1, 2'b01, 4'hF, -1, 0);
        axi_read(32'h1000, 1, 2'b01, 0);
        axi_read(32'h10, 0, 2'b01, 0);
        wbuf[0] = 32'h7777_0001; wbuf[1] = 32'h7777_0002;
        axi_write(32'h40, 1, 2'b01, 4'hF, 0, 0);
        axi_read(32'h40, 1, 2'b01, 0);

        // Back-pressure on B and R
        wbuf[0] = 32'hCAFE_F00D;
        axi_write(32'h80, 0, 2'b01, 4'hF, -1, 5);
        axi_read(32'h80, 0, 2'b01, 5);

        // Reset after 2 of 4 beats: no response, written beats persist
        do_aw(32'h200, 8'd3, 2'b01);
        do_w(32'hA0A0_0000, 4'hF, 1'b0);
        mdl[10'h80] = 32'hA0A0_0000;
        do_w(32'hA1A1_0001, 4'hF, 1'b0);
        mdl[10'h81] = 32'hA1A1_0001;
        rst_n = 1'b0;
        #1;
        chk_idle_zero("midrst");
        step(); step();
        chk_idle_zero("midrst_hold");
        rst_n = 1'b1;
        step();
        chk("midrst_awready", bus.s_axi_awready, 1);
        chk("midrst_arready", bus.s_axi_arready, 1);
        wbuf[0] = 32'h0BAD_C0DE;
        axi_write(32'h300, 0, 2'b01, 4'hF, -1, 0);
        axi_read(32'h200, 1, 2'b01, 0);
        axi_read(32'h300, 0, 2'b01, 0);

        chk("bq_drained", 64'(bq.size()), 0);
        chk("rq_drained", 64'(rq.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width in bits (32/64/128).
REQ-003 SHALL have parameter C_MEM_DEPTH, default 1024, memory depth in data-width words (power of 2).
REQ-004 SHALL use one clock and an asynchronous, active-low reset: s_axi_aclk  in  1  clock; s_axi_aresetn  in  1  async active-low reset.
REQ-005 SHALL have s_axi_awaddr in ADDR_W, s_axi_awlen in 8, s_axi_awsize in 3, s_axi_awburst in 2, s_axi_awvalid in 1, s_axi_awready out 1.
REQ-006 SHALL have s_axi_awlock in 1, s_axi_awcache in 4, s_axi_awprot in 3, s_axi_awqos in 4, all accepted and ignored; same set for ar*.
REQ-007 SHALL have s_axi_wdata in DATA_W, s_axi_wstrb in DATA_W/8, s_axi_wlast in 1, s_axi_wvalid in 1, s_axi_wready out 1.
REQ-008 SHALL have s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1.
REQ-009 SHALL have s_axi_araddr in ADDR_W, s_axi_arlen in 8, s_axi_arsize in 3, s_axi_arburst in 2, s_axi_arvalid in 1, s_axi_arready out 1.
REQ-010 SHALL have s_axi_rdata out DATA_W, s_axi_rresp out 2, s_axi_rlast out 1, s_axi_rvalid out 1, s_axi_rready in 1.

Function
REQ-011 SHALL implement an AXI4 slave (responder) backed by C_MEM_DEPTH x DATA_W memory, one write port, one read port.
REQ-012 SHALL map word index = addr >> log2(DATA_W/8); low byte-offset bits ignored; axsize ignored, every beat full width.
REQ-013 SHALL flag a burst out-of-range when start word index >= C_MEM_DEPTH (any upper address bit set).
REQ-014 SHALL increment word index by 1 per beat for INCR and WRAP (WRAP treated as INCR), hold it for FIXED; index wraps modulo C_MEM_DEPTH.
REQ-015 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-016 W_IDLE -> W_DATA on awvalid&awready; latch address, awlen, awburst, out-of-range flag; clear beat counter.
REQ-017 In W_DATA each wvalid&wready beat SHALL write bytes enabled by wstrb; no write if out-of-range.
REQ-018 Burst SHALL end on beat number awlen+1 -> W_RESP; wlast value at any beat not affecting beat count.
REQ-019 bresp SHALL be SLVERR (2'b10) if out-of-range or wlast disagreed with beat position on any beat, else OKAY (2'b00).
REQ-020 W_RESP -> W_IDLE on bvalid&bready; bvalid/bresp held stable until accepted.
REQ-021 Read FSM SHALL have states R_IDLE, R_FETCH, R_DATA; arready=1 only in R_IDLE, rvalid=1 only in R_DATA.
REQ-022 R_IDLE -> R_FETCH on arvalid&arready; R_FETCH performs synchronous memory read, -> R_DATA next cycle with rdata registered.
REQ-023 First rvalid SHALL assert 2 cycles after AR handshake; each later beat 2 cycles after previous R handshake (50% max throughput).
REQ-024 rlast=1 exactly on beat arlen+1; R_DATA -> R_IDLE on last handshake, else -> R_FETCH.
REQ-025 Out-of-range read SHALL return rdata=0, rresp=SLVERR on every beat; else rresp=OKAY.
REQ-026 rdata/rresp/rlast SHALL stay stable while rvalid=1 and rready=0.
REQ-027 Read and write FSMs SHALL run independently and concurrently; same-word write and read in one cycle returns old data.

Reset
REQ-028 While s_axi_aresetn=0: awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp, rdata = 0; FSMs in W_IDLE/R_IDLE.
REQ-029 awready and arready SHALL be 1 from the first rising edge after reset release.
REQ-030 Reset mid-burst SHALL abandon the burst with no response; memory contents SHALL not be cleared; beats already written persist.

Verification
REQ-031 Write 0x10 len0 data 0xDEADBEEF strb 0xF -> bresp OKAY; read 0x10 len0 -> rdata 0xDEADBEEF, rresp 0, rlast 1, rvalid 2 cycles after AR handshake.
REQ-032 INCR write 0x100 len3 data 1,2,3,4 then INCR read 0x100 len3 -> 1,2,3,4, rlast only on 4th; FIXED read 0x100 len1 -> 1,1.
REQ-033 Over 0xDEADBEEF at 0x20, write 0x0000FFFF strb 0x3 -> read 0xDEADFFFF.
REQ-034 Write/read 0x1000 (DEPTH 1024, DATA 32) -> bresp SLVERR, rdata 0 rresp SLVERR; write len1 wlast on beat 1 -> SLVERR, 2 beats taken.
REQ-035 bready low 5 cycles -> bvalid held 1, awready 0; rready low 5 cycles -> rvalid/rdata held; then handshakes complete.
REQ-036 aresetn low after 2 of 4 write beats -> all valids/readies 0 during reset; after release new write accepted; read shows first 2 beats written.
